pipe_stage_buf: RTL



---
 rtl/pipe_pkg.sv | 20 ++
 rtl/sat_counter.sv | 31 +++
 rtl/pipe_stage_buf.sv | 117 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage buffers: default sizes and pointer-width helper.
package pipe_pkg;

    localparam int unsigned PIPE_DATA_W_DEFAULT = 32;
    localparam int unsigned PIPE_DEPTH_DEFAULT  = 2;
    localparam int unsigned PIPE_CNT_W_DEFAULT  = 16;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int unsigned pipe_clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at its maximum value instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage register: DEPTH-entry circular FIFO with flush and
// saturating stall/bubble counters.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = PIPE_DATA_W_DEFAULT,
    parameter int unsigned DEPTH  = PIPE_DEPTH_DEFAULT,
    parameter int unsigned CNT_W  = PIPE_CNT_W_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic [pipe_clog2(DEPTH):0]  occupancy,
    output logic [CNT_W-1:0]            stall_cnt,
    output logic [CNT_W-1:0]            bubble_cnt
);

    localparam int unsigned PTR_W = pipe_clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic              push;
    logic              pop;
    logic              wr_en;

    assign push  = in_valid & in_ready_q;
    assign pop   = out_valid_q & out_ready;
    assign wr_en = push & ~flush;

    // Next-state for pointers, occupancy and the registered handshake flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            occ_d       = '0;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
            out_valid_d = (occ_d != '0);
            in_ready_d  = (occ_d < OCC_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Storage is zeroed on reset so out_data reads 0 afterwards; flush leaves it intact.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = mem_q[rd_ptr_q];
    assign occupancy = occ_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_valid_q & ~out_ready),
        .cnt   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~out_valid_q & out_ready),
        .cnt   (bubble_cnt)
    );

endmodule
